cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Common Data Bus arbiter and broadcast stage for the Tomasulo core. It collects completed results from N functional units (ALU, branch/CMP, multiply/divide, load), each of which holds its result and valid flag until acknowledged. Each cycle it grants one unit by round-robin, returns the per-unit `cdb_ready` acknowledge, and registers the winner's `cdb_t` onto the CDB. The ROB and all reservation stations consume the CDB broadcast the following cycle.

## Interface
Parameters:
- `N_UNITS`, default 4: number of functional units on the CDB. Must be at least 2.
- `IDX_W`, default `$clog2(N_UNITS)`: width of the grant index and of the round-robin pointer.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset. Synchronous, active-high.
- `flush`, in, 1: mispredict flush; suppresses any grant this cycle.
- `unit_valid`, in, N_UNITS: unit i holds a completed result (the unit's `*_result_valid`).
- `unit_result`, in, N_UNITS x `cdb_t`: each unit's held result.
- `unit_ack`, out, N_UNITS: one-hot or zero. This is unit i's `cdb_ready`; the unit drops its valid on the same edge.
- `cdb_valid`, out, 1: the CDB carries a result this cycle.
- `cdb_out`, out, `cdb_t`: the broadcast result (`rd_data`, `rs1_data`, `rs2_data`, `rob_entry`).
- `cdb_src`, out, IDX_W: index of the unit that produced `cdb_out`, for debug and performance counters.

## Operation
- Round-robin pointer `rr_ptr`, IDX_W bits. It holds the highest-priority index.
- Priority order for a cycle: `rr_ptr`, `rr_ptr+1`, …, wrapping modulo N_UNITS.
- Grant is combinational. `unit_ack[i]` = 1 only when all of these hold:
  - `!rst` and `!flush`;
  - `unit_valid[i]`;
  - i is the first valid unit in priority order.
- On a posedge with a grant to unit i:
  - `cdb_out <= unit_result[i]`, `cdb_valid <= 1`, `cdb_src <= i`;
  - `rr_ptr <= (i+1) mod N_UNITS`, with explicit wrap for non-power-of-2 N_UNITS.
- On a posedge without a grant: `cdb_valid <= 0`. `cdb_out` and `cdb_src` hold their values (don't-care to consumers). `rr_ptr` is unchanged.
- Flush: no ack is issued, `cdb_valid <= 0` next edge, and `rr_ptr` is unchanged. Units clear themselves on their own flush path. A flush does not retract a broadcast already in `cdb_out`; it is valid for its one cycle.
- The CDB cannot stall. Every registered broadcast lasts exactly one cycle.
- Simultaneous events:
  - A unit asserting valid in the same cycle it is granted follows the unit's own rules. Its start overrides the ack, so a new result is held and re-requests next cycle.
  - A unit receiving an ack while it loads a new result is legal.
- Fairness: a unit that holds `unit_valid` continuously is granted within N_UNITS cycles.

## Timing
- Reset values:
  - `cdb_valid` = 0, `cdb_out` = '0, `cdb_src` = 0, `rr_ptr` = 0.
  - `unit_ack` = 0 while `rst` is high.
- Reset mid-operation: a result pending in a unit is not acked. The broadcast register clears on that edge.
- Latency: `unit_valid` high in cycle t with a grant gives `unit_ack` in cycle t and `cdb_valid` / `cdb_out` in cycle t+1.
- Throughput: one result per cycle. Back-to-back grants to different units or to the same unit are allowed.
- No combinational path from `unit_result` to `cdb_out`. `unit_valid` → `unit_ack` is combinational and is the only comb path.

## Structure
- `cdb_t` and the ROB index width live in `rv32i_types`.
- `N_UNITS` and unit index constants (`CDB_ALU`, `CDB_CMP`, `CDB_MUL`, `CDB_LD`) are added to `rv32i_types` so RS/unit wiring is consistent.
- Sub-module `rr_arbiter` (parameter N). It holds `rr_ptr` and has these ports:
  - inputs: `req`[N], `en`;
  - outputs: `gnt`[N] (one-hot), `gnt_idx`, `gnt_any`;
  - `rr_ptr` advances inside on `en && gnt_any`.
- `cdb_arbiter` adds the result mux and the broadcast register.

## Test plan
- Single request, N=4: `unit_valid`=0010 in cycle 5. Expect `unit_ack`=0010 in cycle 5, and `cdb_valid`=1 with `cdb_src`=1 and `rob_entry` matching in cycle 6. `rr_ptr` becomes 2.
- Contention rotation: all four units held valid from reset. Expect grants 0,1,2,3,0 on consecutive cycles, each `cdb_out` equal to that unit's result, and `cdb_valid` continuously 1.
- Wrap-around: `rr_ptr`=3, `unit_valid`=1001. Expect grant to unit 3, then to unit 0 next cycle. Repeat with N_UNITS=3, where the pointer goes 2→0.
- Fairness: unit 0 re-asserts valid every cycle while unit 2 holds valid. Expect unit 2 granted within 4 cycles and no starvation over 1000 random cycles.
- Flush: `flush`=1 with `unit_valid`=0110. Expect `unit_ack`=0000, `cdb_valid`=0 next cycle, and `rr_ptr` unchanged. After flush deasserts, the grant resumes from the same pointer.
- Reset mid-operation: assert `rst` while `cdb_valid`=1 and unit 1 is pending. Expect `unit_ack`=0, then `cdb_valid`=0, `cdb_out`=0 and `rr_ptr`=0 after the edge.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: CDB result type, unit count and unit index constants
package cdb_arbiter_pkg;
  localparam int ROB_IDX_W = 4;
  localparam int CDB_N_UNITS = 4;
  localparam int CDB_ALU = 0;
  localparam int CDB_CMP = 1;
  localparam int CDB_MUL = 2;
  localparam int CDB_LD = 3;
  typedef struct packed {
    logic [31:0] rd_data;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [ROB_IDX_W-1:0] rob_entry;
  } cdb_t;
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: functional-unit request side and CDB broadcast side of the arbiter
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int N_UNITS = CDB_N_UNITS,
  parameter int IDX_W = $clog2(N_UNITS)
);
  logic flush;
  logic [N_UNITS-1:0] unit_valid;
  logic [N_UNITS-1:0] unit_ack;
  cdb_t [N_UNITS-1:0] unit_result;
  logic cdb_valid;
  cdb_t cdb_out;
  logic [IDX_W-1:0] cdb_src;
  modport master (
    output flush, unit_valid, unit_result,
    input unit_ack, cdb_valid, cdb_out, cdb_src
  );
  modport slave (
    input flush, unit_valid, unit_result,
    output unit_ack, cdb_valid, cdb_out, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter_rr.sv
// rr_arbiter: round-robin one-hot grant with a rotating highest-priority pointer
module rr_arbiter #(
  parameter int N = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_i,
  input  logic             en_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_any_o
);
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, idx;
  // scan from farthest to nearest so the first requester at or after rr_ptr_q wins
  always_comb begin
    gnt_o = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(rr_ptr_q) + k) % N);
      if (en_i && req_i[idx]) begin
        gnt_o = '0;
        gnt_o[idx] = 1'b1;
        gnt_idx_o = idx;
        gnt_any_o = 1'b1;
      end
    end
  end
  assign rr_ptr_d = !gnt_any_o ? rr_ptr_q :
                    gnt_idx_o == IDX_W'(N - 1) ? '0 : gnt_idx_o + IDX_W'(1);
  // pointer moves just past the winner so it becomes lowest priority
  always_ff @(posedge clk) rr_ptr_q <= rst ? '0 : rr_ptr_d;
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants one functional unit per cycle and registers its result onto the CDB
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_UNITS = CDB_N_UNITS,
  parameter int IDX_W = $clog2(N_UNITS)
) (
  input logic         clk,
  input logic         rst,
  cdb_arbiter_if.slave bus
);
  logic [N_UNITS-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx, cdb_src_q;
  logic gnt_any, cdb_valid_q;
  cdb_t cdb_out_q;
  rr_arbiter #(.N(N_UNITS), .IDX_W(IDX_W)) u_rr (
    .clk(clk),
    .rst(rst),
    .req_i(bus.unit_valid),
    .en_i(!rst && !bus.flush),
    .gnt_o(gnt),
    .gnt_idx_o(gnt_idx),
    .gnt_any_o(gnt_any)
  );
  // broadcast register: valid for exactly one cycle per grant, payload held otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q <= 1'b0;
      cdb_out_q <= '0;
      cdb_src_q <= '0;
    end else begin
      cdb_valid_q <= gnt_any;
      if (gnt_any) begin
        cdb_out_q <= bus.unit_result[gnt_idx];
        cdb_src_q <= gnt_idx;
      end
    end
  end
  assign bus.unit_ack = gnt;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_out = cdb_out_q;
  assign bus.cdb_src = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: randomized self-checking bench against a first-valid-after-pointer model
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  int m_ptr = 0, m_src = 0, last_g = -1;
  logic m_valid = 1'b0;
  cdb_t m_out = '0;
  int m3_ptr = 0, m3_src = 0;
  cdb_t m3_out = '0;
  always #5 clk = ~clk;
  cdb_arbiter_if #(.N_UNITS(4)) bus4 ();
  cdb_arbiter_if #(.N_UNITS(3)) bus3 ();
  cdb_arbiter #(.N_UNITS(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  cdb_arbiter #(.N_UNITS(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  function automatic int pick(int p, logic [3:0] v, int n);
    for (int k = 0; k < n; k++) if (v[(p + k) % n]) return (p + k) % n;
    return -1;
  endfunction

  function automatic cdb_t rnd_res();
    cdb_t r;
    r.rd_data = $urandom;
    r.rs1_data = $urandom;
    r.rs2_data = $urandom;
    r.rob_entry = 4'($urandom);
    return r;
  endfunction

  task automatic step4(input logic r, input logic fl, input logic [3:0] v);
    int g;
    logic [3:0] ea;
    cdb_t res;
    rst = r;
    bus4.flush = fl;
    bus4.unit_valid = v;
    for (int i = 0; i < 4; i++) bus4.unit_result[i] = rnd_res();
    #1;
    g = (r || fl) ? -1 : pick(m_ptr, v, 4);
    ea = g < 0 ? 4'b0 : 4'(1 << g);
    res = g < 0 ? '0 : bus4.unit_result[g];
    checks++;
    if (bus4.unit_ack !== ea) begin
      errors++;
      $display("FAIL ack: got %b want %b (valid=%b flush=%b rst=%b)", bus4.unit_ack, ea, v, fl, r);
    end
    @(posedge clk);
    #1;
    if (r) begin
      m_valid = 1'b0; m_out = '0; m_src = 0; m_ptr = 0;
    end else if (g >= 0) begin
      m_valid = 1'b1; m_out = res; m_src = g; m_ptr = (g + 1) % 4;
    end else m_valid = 1'b0;
    last_g = g;
    checks++;
    if (bus4.cdb_valid !== m_valid) begin
      errors++;
      $display("FAIL cdb_valid: got %b want %b", bus4.cdb_valid, m_valid);
    end
    checks++;
    if (bus4.cdb_out !== m_out) begin
      errors++;
      $display("FAIL cdb_out: got %h want %h", bus4.cdb_out, m_out);
    end
    checks++;
    if (int'(bus4.cdb_src) !== m_src) begin
      errors++;
      $display("FAIL cdb_src: got %0d want %0d", bus4.cdb_src, m_src);
    end
    checks++;
    if (int'(dut4.u_rr.rr_ptr_q) !== m_ptr) begin
      errors++;
      $display("FAIL rr_ptr: got %0d want %0d", dut4.u_rr.rr_ptr_q, m_ptr);
    end
  endtask

  task automatic step3(input logic [2:0] v);
    int g;
    logic [2:0] ea;
    cdb_t res;
    rst = 1'b0;
    bus4.unit_valid = '0;
    bus3.flush = 1'b0;
    bus3.unit_valid = v;
    for (int i = 0; i < 3; i++) bus3.unit_result[i] = rnd_res();
    #1;
    g = pick(m3_ptr, {1'b0, v}, 3);
    ea = g < 0 ? 3'b0 : 3'(1 << g);
    res = g < 0 ? '0 : bus3.unit_result[g];
    checks++;
    if (bus3.unit_ack !== ea) begin
      errors++;
      $display("FAIL n3_ack: got %b want %b", bus3.unit_ack, ea);
    end
    @(posedge clk);
    #1;
    if (g >= 0) begin
      m3_out = res; m3_src = g; m3_ptr = (g + 1) % 3;
    end
    checks++;
    if (bus3.cdb_valid !== (g >= 0) || bus3.cdb_out !== m3_out || int'(bus3.cdb_src) !== m3_src) begin
      errors++;
      $display("FAIL n3_cdb: got v=%b src=%0d out=%h want v=%b src=%0d out=%h",
               bus3.cdb_valid, bus3.cdb_src, bus3.cdb_out, g >= 0, m3_src, m3_out);
    end
    checks++;
    if (int'(dut3.u_rr.rr_ptr_q) !== m3_ptr) begin
      errors++;
      $display("FAIL n3_ptr: got %0d want %0d", dut3.u_rr.rr_ptr_q, m3_ptr);
    end
  endtask

  task automatic test_reset();
    step4(1'b1, 1'b0, 4'b1111);
    step4(1'b1, 1'b0, 4'b0101);
  endtask

  task automatic test_single();
    step4(1'b0, 1'b0, 4'b0000);
    step4(1'b0, 1'b0, 4'b0000);
    step4(1'b0, 1'b0, 4'b0010);
    step4(1'b0, 1'b0, 4'b0000);
  endtask

  task automatic test_rotation();
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    step4(1'b1, 1'b0, 4'b1111);
    for (int i = 0; i < 5; i++) begin
      step4(1'b0, 1'b0, 4'b1111);
      checks++;
      if (last_g !== exp_seq[i] || bus4.cdb_valid !== 1'b1) begin
        errors++;
        $display("FAIL rotation[%0d]: got src=%0d valid=%b want src=%0d valid=1", i, bus4.cdb_src, bus4.cdb_valid, exp_seq[i]);
      end
    end
  endtask

  task automatic test_wrap();
    step4(1'b0, 1'b0, 4'b0100);
    step4(1'b0, 1'b0, 4'b1001);
    step4(1'b0, 1'b0, 4'b1001);
  endtask

  task automatic test_flush();
    step4(1'b0, 1'b0, 4'b0001);
    step4(1'b0, 1'b1, 4'b0110);
    step4(1'b0, 1'b0, 4'b0110);
    step4(1'b0, 1'b0, 4'b0100);
  endtask

  task automatic test_fairness();
    logic [3:0] held;
    int age[4];
    bit seen;
    held = 4'b0101;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      step4(1'b0, 1'b0, held);
      seen = (last_g == 2);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL fair_u2: got no grant to unit 2 in 4 cycles, want one");
    end
    held = 4'b0001;
    for (int i = 0; i < 4; i++) age[i] = 0;
    for (int c = 0; c < 1000; c++) begin
      logic fl;
      fl = ($urandom_range(0, 19) == 0);
      step4(1'b0, fl, held);
      for (int i = 0; i < 4; i++) begin
        if (fl || last_g == i || !held[i]) age[i] = 0;
        else age[i]++;
        checks++;
        if (age[i] >= 4) begin
          errors++;
          $display("FAIL starve: unit %0d waited %0d cycles, want < 4", i, age[i]);
        end
      end
      for (int i = 1; i < 4; i++)
        held[i] = (held[i] && last_g != i) || ($urandom_range(0, 2) == 0);
    end
  endtask

  task automatic test_reset_mid();
    step4(1'b0, 1'b0, 4'b0011);
    step4(1'b1, 1'b0, 4'b0010);
    step4(1'b0, 1'b0, 4'b1110);
  endtask

  task automatic test_n3();
    step3(3'b010);
    step3(3'b101);
    step3(3'b101);
    step3(3'b111);
    step3(3'b111);
  endtask

  initial begin
    bus4.flush = 1'b0;
    bus4.unit_valid = '0;
    bus4.unit_result = '0;
    bus3.flush = 1'b0;
    bus3.unit_valid = '0;
    bus3.unit_result = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_flush();
    test_fairness();
    test_reset_mid();
    test_n3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
